// File: rtl/bfedp_pkg.sv
// Shared widths, FSM state type and small helpers for the bit-column weight encoder.
package bfedp_pkg;

  localparam int LANES    = 8;
  localparam int SLOTS    = 4;
  localparam int MAG_BITS = 7;
  localparam int OFS_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef logic [SLOTS*OFS_W-1:0] ofs_vec_t;

  function automatic logic [2:0] popcount7(input logic [MAG_BITS-1:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < MAG_BITS; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

  // -128 has no int8 magnitude, so it saturates to 127
  function automatic logic [MAG_BITS-1:0] mag7(input logic [7:0] w);
    logic [7:0] neg;
    neg = 8'd0 - w;
    if (w == 8'h80) begin
      return 7'h7F;
    end else if (w[7]) begin
      return neg[MAG_BITS-1:0];
    end else begin
      return w[MAG_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/bfedp_weight_encoder_bcol_pick4.sv
// Picks the four lowest set bit-column indices of a remaining-column mask.
module bcol_pick4
  import bfedp_pkg::*;
(
  input  logic [MAG_BITS-1:0] mask_i,
  output ofs_vec_t            ofs_o,
  output logic [SLOTS-1:0]    slot_vld_o,
  output logic [MAG_BITS-1:0] mask_clr_o
);

  logic [MAG_BITS-1:0] m;
  logic                found;

  always_comb begin
    m          = mask_i;
    ofs_o      = '0;
    slot_vld_o = '0;
    found      = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      found = 1'b0;
      for (int j = 0; j < MAG_BITS; j++) begin
        if (!found && m[j]) begin
          found                  = 1'b1;
          ofs_o[s*OFS_W +: OFS_W] = OFS_W'(j);
          slot_vld_o[s]          = 1'b1;
          m[j]                   = 1'b0;
        end
      end
    end
    mask_clr_o = m;
  end

endmodule

// File: rtl/bfedp_weight_encoder.sv
// Converts a group of eight int8 weights into up to two beats of bit-column masks with shift offsets.
module bfedp_weight_encoder
  import bfedp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*8-1:0]     in_weights,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       weight_column0,
  output logic [LANES-1:0]       weight_column1,
  output logic [LANES-1:0]       weight_column2,
  output logic [LANES-1:0]       weight_column3,
  output logic [LANES-1:0]       weight_sign,
  output logic [SLOTS*OFS_W-1:0] shift_offset,
  output logic                   out_last,
  output logic [2:0]             col_count
);

  state_t                            state_q;
  logic [MAG_BITS-1:0][LANES-1:0]    cols_q;
  logic [LANES-1:0]                  sign_q;
  logic [MAG_BITS-1:0]               rem_q;
  logic [2:0]                        cnt_q;

  logic [MAG_BITS-1:0][LANES-1:0]    cols_d;
  logic [LANES-1:0]                  sign_d;
  logic [MAG_BITS-1:0]               nz_d;
  logic [MAG_BITS-1:0]               rem_d;
  logic [MAG_BITS-1:0]               mag [LANES];

  ofs_vec_t                          pick_ofs;
  logic [SLOTS-1:0]                  pick_vld;
  logic [LANES-1:0]                  col_sel [SLOTS];
  logic                              emit;

  always_comb begin
    cols_d = '0;
    sign_d = '0;
    nz_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      mag[i]    = mag7(in_weights[8*i +: 8]);
      sign_d[i] = in_weights[8*i+7];
    end
    for (int j = 0; j < MAG_BITS; j++) begin
      for (int i = 0; i < LANES; i++) begin
        cols_d[j][i] = mag[i][j];
      end
      nz_d[j] = |cols_d[j];
    end
  end

  bcol_pick4 u_pick (
    .mask_i     (rem_q),
    .ofs_o      (pick_ofs),
    .slot_vld_o (pick_vld),
    .mask_clr_o (rem_d)
  );

  assign emit = (state_q == EMIT);

  // in_ready must read 0 while reset is held, even though state already sits in IDLE
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = emit;
  assign out_last  = emit && (rem_d == '0);

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      col_sel[s] = '0;
      if (emit && pick_vld[s]) begin
        col_sel[s] = cols_q[pick_ofs[s*OFS_W +: OFS_W]];
      end
    end
  end

  assign weight_column0 = col_sel[0];
  assign weight_column1 = col_sel[1];
  assign weight_column2 = col_sel[2];
  assign weight_column3 = col_sel[3];
  assign weight_sign    = emit ? sign_q : '0;
  assign shift_offset   = emit ? pick_ofs : '0;
  assign col_count      = emit ? cnt_q : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cols_q  <= '0;
      sign_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cols_q  <= cols_d;
            sign_q  <= sign_d;
            rem_q   <= nz_d;
            cnt_q   <= popcount7(nz_d);
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            rem_q <= rem_d;
            if (rem_d == '0) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfedp_weight_encoder.sv
// Directed bench for the bit-column weight encoder: fixed groups with hand-computed beats.
module tb_bfedp_weight_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_weights = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  weight_column0, weight_column1, weight_column2, weight_column3;
  logic [7:0]  weight_sign;
  logic [11:0] shift_offset;
  logic        out_last;
  logic [2:0]  col_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bfedp_weight_encoder dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_weights     (in_weights),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .weight_column0 (weight_column0),
    .weight_column1 (weight_column1),
    .weight_column2 (weight_column2),
    .weight_column3 (weight_column3),
    .weight_sign    (weight_sign),
    .shift_offset   (shift_offset),
    .out_last       (out_last),
    .col_count      (col_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag,
                          input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3,
                          input logic [11:0] ofs, input logic [7:0] sgn,
                          input logic last, input logic [2:0] cnt);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".ready"}, 64'(in_ready), 64'd0);
    chk({tag, ".col0"}, 64'(weight_column0), 64'(c0));
    chk({tag, ".col1"}, 64'(weight_column1), 64'(c1));
    chk({tag, ".col2"}, 64'(weight_column2), 64'(c2));
    chk({tag, ".col3"}, 64'(weight_column3), 64'(c3));
    chk({tag, ".ofs"}, 64'(shift_offset), 64'(ofs));
    chk({tag, ".sign"}, 64'(weight_sign), 64'(sgn));
    chk({tag, ".last"}, 64'(out_last), 64'(last));
    chk({tag, ".cnt"}, 64'(col_count), 64'(cnt));
  endtask

  // Offers a group and returns #1 after the acceptance edge; input then changes to junk.
  task automatic send(input string tag, input logic [63:0] w);
    int waited;
    in_valid   = 1'b1;
    in_weights = w;
    waited     = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, ".accept_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_weights = 64'hA5C3_7E19_0F81_6D24;
  endtask

  task automatic take_beat();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst.ready", 64'(in_ready), 64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.last", 64'(out_last), 64'd0);
    chk("rst.col0", 64'(weight_column0), 64'd0);
    chk("rst.ofs", 64'(shift_offset), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel.ready", 64'(in_ready), 64'd1);
    chk("rel.valid", 64'(out_valid), 64'd0);

    // all lanes +3
    send("t3", 64'h0303_0303_0303_0303);
    chk_beat("t3", 8'hFF, 8'hFF, 8'h00, 8'h00, 12'h008, 8'h00, 1'b1, 3'd2);
    take_beat();
    chk("t3.done_valid", 64'(out_valid), 64'd0);
    chk("t3.done_ready", 64'(in_ready), 64'd1);

    // lane0 = -128 with 5 cycles of backpressure on beat 0
    send("m128", 64'h0000_0000_0000_0080);
    chk_beat("m128.b0", 8'h01, 8'h01, 8'h01, 8'h01, 12'h688, 8'h01, 1'b0, 3'd7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_beat("m128.hold", 8'h01, 8'h01, 8'h01, 8'h01, 12'h688, 8'h01, 1'b0, 3'd7);
    end
    take_beat();
    chk_beat("m128.b1", 8'h01, 8'h01, 8'h01, 8'h00, 12'h1AC, 8'h01, 1'b1, 3'd7);
    take_beat();
    chk("m128.done_valid", 64'(out_valid), 64'd0);

    // all-zero group
    send("zero", 64'h0);
    chk_beat("zero", 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 8'h00, 1'b1, 3'd0);
    take_beat();
    chk("zero.done_ready", 64'(in_ready), 64'd1);
    chk("zero.done_valid", 64'(out_valid), 64'd0);

    // lane0 = -1, lane1 = +64
    send("mix", 64'h0000_0000_0000_40FF);
    chk_beat("mix", 8'h01, 8'h02, 8'h00, 8'h00, 12'h030, 8'h01, 1'b1, 3'd2);
    take_beat();

    // reset during beat 1 of the -128 group
    send("rmid", 64'h0000_0000_0000_0080);
    take_beat();
    chk_beat("rmid.b1", 8'h01, 8'h01, 8'h01, 8'h00, 12'h1AC, 8'h01, 1'b1, 3'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid.valid", 64'(out_valid), 64'd0);
    chk("rmid.ready", 64'(in_ready), 64'd0);
    chk("rmid.col0", 64'(weight_column0), 64'd0);
    chk("rmid.sign", 64'(weight_sign), 64'd0);
    chk("rmid.last", 64'(out_last), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rmid.rel_ready", 64'(in_ready), 64'd1);
    chk("rmid.rel_valid", 64'(out_valid), 64'd0);
    send("post", 64'h0303_0303_0303_0303);
    chk_beat("post", 8'hFF, 8'hFF, 8'h00, 8'h00, 12'h008, 8'h00, 1'b1, 3'd2);
    take_beat();
    chk("post.done_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bfedp_weight_encoder.md
# bfedp_weight_encoder

Bit-column weight encoder that produces the inputs of the bit-sparse fused dot-product engine. It takes a group of eight signed int8 weights and converts them to sign-magnitude. It finds the non-zero magnitude bit-columns and emits them, at most four per beat, as bit-column masks with 3-bit shift offsets. It sits between the weight buffer and the dot-product array; the consumer accumulates the beats of one group through its partial-sum input.

## Interface
Parameters: none; all widths are fixed and come from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  weight group valid
- in_ready  out  1  encoder can accept a group
- in_weights  in  64  8 lanes of signed int8; lane i at [8i+7:8i]
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts the beat
- weight_column0..3  out  8 each  bit-column masks for slots 0..3; bit i belongs to lane i
- weight_sign  out  8  bit i = 1 when lane i is negative
- shift_offset  out  12  slot s column index at [3s+2:3s]
- out_last  out  1  final beat of the group
- col_count  out  3  number of non-zero columns in the group, 0..7

## Operation
- Magnitude: |w|, with -128 clamped to 127, giving 7 bits. sign_i = w_i[7].
- Column j (0..6) = {mag_7[j], …, mag_0[j]}. nz_mask[j] = (column j != 0).
- Beats per group = max(1, ceil(popcount(nz_mask)/4)), so 1 or 2.
- Slots are filled with the lowest-index remaining non-zero columns, in ascending order into slot 0 upward. Unused slots output column 0x00 and offset 0.
- FSM:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, register sign, all 7 columns, rem_mask=nz_mask and col_count, then go to EMIT.
  - EMIT: in_ready=0, out_valid=1. Outputs are driven combinationally from the registered state.
    - out_last = (popcount(rem_mask) <= 4).
    - On out_valid&&out_ready: clear the emitted columns from rem_mask. Go to IDLE if out_last, else stay in EMIT.
- An all-zero group emits one beat with all columns 0x00, offsets 0, out_last=1 and col_count=0.
- weight_sign and col_count are constant across the beats of a group.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after release; out_valid=0; out_last=0; all data outputs 0; FSM=IDLE; stored group cleared.
- Latency: accept at edge k, then out_valid=1 from cycle k+1.
- Group cost is beats+1 cycles, because of the IDLE acceptance bubble. There is no overlap.
- AXI-style handshake:
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - out_valid never drops without a handshake.
  - in_weights is sampled only on the acceptance edge.
- Reset asserted mid-group: outputs clear asynchronously, the pending group is dropped and no partial beat is replayed.

## Structure
- Package bfedp_pkg holds:
  - constants LANES=8, SLOTS=4, MAG_BITS=7, OFS_W=3;
  - a state enum {IDLE, EMIT};
  - a typedef for the packed 12-bit offset vector.
- Sub-module bcol_pick4: combinational. It takes the 7-bit rem_mask and returns up to four lowest set indices, a 4-bit slot-valid vector and the post-clear mask.
- The top level holds the FSM, the column/sign registers and the output muxing.

## Test plan
- All lanes = 3: one beat, columns0=0xFF, column1=0xFF, columns2,3=0x00, shift_offset=12'h008, weight_sign=0x00, out_last=1, col_count=2.
- Lane0 = -128, other lanes 0:
  - beat 0: columns0..3=0x01, shift_offset=12'h688, out_last=0;
  - beat 1: columns0..2=0x01, column3=0x00, shift_offset=12'h1AC, out_last=1;
  - both beats: weight_sign=0x01, col_count=7.
- All-zero group: one beat with all columns 0x00, shift_offset=0, out_last=1, col_count=0; in_ready returns to 1 the cycle after the handshake.
- Lanes = {-1, +64, 0×6} (lane0 = -1, lane1 = +64): columns0=0x01 (offset 0), column1=0x02 (offset 6), shift_offset=12'h030, weight_sign=0x01, one beat.
- Backpressure: hold out_ready=0 for 5 cycles on beat 0 of the -128 case; outputs stay stable and in_ready stays 0. Then beat 1 follows correctly.
- Assert rst during beat 1 of the -128 case: out_valid=0 immediately; after release in_ready=1, and a new group (all lanes 3) produces the first-case output.
